// File: rtl/instr_fetch_unit_pkg.sv
// Shared constants and types for the instruction fetch unit.
package instr_fetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_INC           = 32'd4;
  localparam logic [31:0] PC_READ_OFS      = 32'd8;

  // One buffered fetch result: the word and the address it was fetched from.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] instr;
  } fetch_entry_t;

  // Clear the byte-offset bits so every fetch address is word aligned.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit and memory.
interface instr_fetch_unit_if;

  logic        IMemReqValid;
  logic [31:0] IMemReqAddr;
  logic        IMemReqReady;
  logic        IMemRespValid;
  logic [31:0] IMemRespData;

  // Fetch side issues requests and consumes responses.
  modport master (
    output IMemReqValid, IMemReqAddr,
    input  IMemReqReady, IMemRespValid, IMemRespData
  );

  // Memory side accepts requests and returns words in order.
  modport slave (
    input  IMemReqValid, IMemReqAddr,
    output IMemReqReady, IMemRespValid, IMemRespData
  );

endinterface

// File: rtl/instr_fetch_unit_fifo.sv
// DEPTH-entry synchronous FIFO of {addr, instr}; flush beats push and pop.
module instr_fifo
  import instr_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  fetch_entry_t               wdata_i,
  output fetch_entry_t               rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_entry_t  entry_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == DEPTH_C);
  assign count_o = count_q;
  assign rdata_o = entry_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Write the incoming entry at the tail.
  // NOTE: the storage array is deliberately not reset; count_q alone marks which entries are live.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) begin
      entry_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Next pointers and occupancy; a flush returns everything to empty.
  // NOTE: every output gets a default first so no path holds a stale value (no latch inferred).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_d = count_q + 1'b1;
      else if (!do_push && do_pop) count_d = count_q - 1'b1;
    end
  end

  // Pointer and count registers with synchronous reset.
  // NOTE: non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues credit-limited in-order memory requests,
// buffers returned words and squashes wrong-path responses after a redirect.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 2
) (
  input  logic                      CLK,
  input  logic                      RESET,
  instr_fetch_unit_if.master        imem,
  input  logic                      PCSrc,
  input  logic [31:0]               BranchTarget,
  output logic [31:0]               Instr,
  output logic [31:0]               PCPlus8,
  output logic                      InstrValid,
  input  logic                      InstrReady
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] in_flight_q, in_flight_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   credit_used;
  logic          fifo_full, fifo_empty;
  logic          req_accept, consume, redirect, resp_drop, push;
  fetch_entry_t  head, push_entry;

  // Requests in flight plus buffered words may never exceed the FIFO size.
  assign credit_used       = {1'b0, in_flight_q} + {1'b0, fifo_count};
  assign imem.IMemReqValid = !RESET && (credit_used < DEPTH_W);
  assign imem.IMemReqAddr  = fetch_pc_q;
  assign req_accept        = imem.IMemReqValid && imem.IMemReqReady;

  assign InstrValid = !fifo_empty;
  assign consume    = InstrValid && InstrReady;
  assign redirect   = consume && PCSrc;

  // A response is dropped while old-path words are still owed, or when it
  // lands in the very cycle the pipe redirects.
  assign resp_drop  = (discard_q != '0) || redirect;
  assign push       = imem.IMemRespValid && !resp_drop && (!fifo_full || consume);
  assign push_entry = '{addr: resp_pc_q, instr: imem.IMemRespData};

  // Outputs read as zero whenever nothing is buffered.
  assign Instr   = fifo_empty ? '0 : head.instr;
  assign PCPlus8 = fifo_empty ? '0 : head.addr + PC_READ_OFS;

  instr_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_i   (RESET),
    .push_i  (push),
    .pop_i   (consume),
    .flush_i (redirect),
    .wdata_i (push_entry),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Next PC, in-flight count, discard count and the address tag of the next kept response.
  always_comb begin
    in_flight_d = in_flight_q;
    if (req_accept && !imem.IMemRespValid)      in_flight_d = in_flight_q + 1'b1;
    else if (!req_accept && imem.IMemRespValid) in_flight_d = in_flight_q - 1'b1;

    discard_d = discard_q;
    if (redirect) begin
      // Everything still unanswered after this edge belongs to the old path.
      discard_d = in_flight_d;
    end else if (imem.IMemRespValid && (discard_q != '0)) begin
      discard_d = discard_q - 1'b1;
    end

    fetch_pc_d = fetch_pc_q;
    if (redirect)        fetch_pc_d = align_word(BranchTarget);
    else if (req_accept) fetch_pc_d = fetch_pc_q + PC_INC;

    // Kept responses are consecutive words starting at the last redirect target.
    resp_pc_d = resp_pc_q;
    if (redirect)  resp_pc_d = align_word(BranchTarget);
    else if (push) resp_pc_d = resp_pc_q + PC_INC;
  end

  // Fetch-state registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      fetch_pc_q  <= RESET_PC;
      resp_pc_q   <= RESET_PC;
      in_flight_q <= '0;
      discard_q   <= '0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      resp_pc_q   <= resp_pc_d;
      in_flight_q <= in_flight_d;
      discard_q   <= discard_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: an in-order memory model answers
// requests, expected fetch addresses are queued and compared on consume.
`timescale 1ns/1ps
module tb_instr_fetch_unit;
  import instr_fetch_unit_pkg::*;

  localparam logic [31:0] PC_A    = 32'h0000_0000;
  localparam int          DEPTH_A = 2;
  localparam logic [31:0] PC_B    = 32'hFFFF_FFF8;
  localparam int          DEPTH_B = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b, sel_b;
  logic        pc_src, mem_ready, resp_valid, instr_ready;
  logic [31:0] branch_target, resp_data;
  logic [31:0] instr_a, pcp8_a, instr_b, pcp8_b;
  logic        ivalid_a, ivalid_b;

  instr_fetch_unit_if if_a ();
  instr_fetch_unit_if if_b ();

  assign if_a.IMemReqReady  = mem_ready;
  assign if_a.IMemRespValid = resp_valid;
  assign if_a.IMemRespData  = resp_data;
  assign if_b.IMemReqReady  = mem_ready;
  assign if_b.IMemRespValid = resp_valid;
  assign if_b.IMemRespData  = resp_data;

  instr_fetch_unit #(.RESET_PC(PC_A), .DEPTH(DEPTH_A)) u_dut_a (
    .CLK(clk), .RESET(rst_a), .imem(if_a), .PCSrc(pc_src), .BranchTarget(branch_target),
    .Instr(instr_a), .PCPlus8(pcp8_a), .InstrValid(ivalid_a), .InstrReady(instr_ready)
  );

  instr_fetch_unit #(.RESET_PC(PC_B), .DEPTH(DEPTH_B)) u_dut_b (
    .CLK(clk), .RESET(rst_b), .imem(if_b), .PCSrc(pc_src), .BranchTarget(branch_target),
    .Instr(instr_b), .PCPlus8(pcp8_b), .InstrValid(ivalid_b), .InstrReady(instr_ready)
  );

  // Observe whichever DUT is active; the idle one is held in reset.
  logic        o_req_valid, o_ivalid;
  logic [31:0] o_req_addr, o_instr, o_pcp8;
  always_comb begin
    if (sel_b) begin
      o_req_valid = if_b.IMemReqValid; o_req_addr = if_b.IMemReqAddr;
      o_ivalid = ivalid_b; o_instr = instr_b; o_pcp8 = pcp8_b;
    end else begin
      o_req_valid = if_a.IMemReqValid; o_req_addr = if_a.IMemReqAddr;
      o_ivalid = ivalid_a; o_instr = instr_a; o_pcp8 = pcp8_a;
    end
  end

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mem_req_t;

  mem_req_t    mem_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] exp_req_q[$];
  logic [31:0] exp_tail;
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc, mem_lat, redir_mode;
  int          first_accept, first_valid, n_accept, n_consume;
  bit          rand_ready, rand_consume, rand_lat, redir_done;
  logic        base_ready, base_consume;
  logic [31:0] redir_target;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic refill();
    while (exp_q.size() < 8) begin
      exp_q.push_back(exp_tail);
      exp_tail = exp_tail + 32'd4;
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, observe handshakes, score.
  task automatic step();
    bit          accept, take, resp_now, in_rst, fire;
    logic [31:0] e;
    @(negedge clk);
    in_rst        = sel_b ? rst_b : rst_a;
    resp_now      = !in_rst && (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    resp_valid    = resp_now;
    resp_data     = resp_now ? mem_word(mem_q[0].addr) : 32'h0;
    mem_ready     = rand_ready   ? ($urandom_range(0, 3) != 0) : base_ready;
    instr_ready   = rand_consume ? ($urandom_range(0, 2) != 0) : base_consume;
    pc_src        = 1'b0;
    branch_target = 32'h0;
    #1;
    if (!in_rst) begin
      accept = o_req_valid && mem_ready;
      take   = o_ivalid && instr_ready;
      fire   = 1'b0;
      if (take) begin
        case (redir_mode)
          1:       fire = (mem_q.size() >= 2);
          2:       fire = accept && resp_now;
          3:       fire = ($urandom_range(0, 7) == 0);
          default: fire = 1'b0;
        endcase
      end
      if (fire) begin
        pc_src        = 1'b1;
        branch_target = (redir_mode == 3) ? ($urandom & 32'h0000_FFFF) : redir_target;
        if (redir_mode != 3) begin
          redir_mode = 0;
          redir_done = 1'b1;
        end
        #1;
      end
      if (o_ivalid && first_valid < 0) first_valid = cyc;
      if (resp_now) void'(mem_q.pop_front());
      if (accept) begin
        if (first_accept < 0) first_accept = cyc;
        n_accept++;
        if (exp_req_q.size() > 0) check("req_addr", o_req_addr, exp_req_q.pop_front());
        mem_q.push_back('{addr: o_req_addr, due: cyc + (rand_lat ? int'($urandom_range(1, 3)) : mem_lat)});
      end
      if (take) begin
        n_consume++;
        if (exp_q.size() == 0) begin
          check("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("instr", o_instr, mem_word(e));
          check("pc_plus8", o_pcp8, e + 32'd8);
        end
        if (pc_src) begin
          exp_q.delete();
          exp_tail = {branch_target[31:2], 2'b00};
        end
      end
      refill();
    end
    cyc++;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset(input bit use_b);
    sel_b = use_b;
    rst_a = 1'b1;
    rst_b = 1'b1;
    step();
    step();
    mem_q.delete();
    exp_q.delete();
    exp_req_q.delete();
    exp_tail = use_b ? PC_B : PC_A;
    refill();
    if (use_b) rst_b = 1'b0; else rst_a = 1'b0;
    resp_valid = 1'b0; mem_ready = 1'b0; instr_ready = 1'b0; pc_src = 1'b0;
    cyc = 0; first_accept = -1; first_valid = -1; n_accept = 0; n_consume = 0;
    redir_mode = 0; redir_done = 1'b0;
    rand_ready = 1'b0; rand_consume = 1'b0; rand_lat = 1'b0;
    @(negedge clk);
    #1;
    check("rst_instr_valid", 32'(o_ivalid), 32'd0);
    check("rst_instr", o_instr, 32'h0);
    check("rst_pc_plus8", o_pcp8, 32'h0);
    check("rst_req_valid", 32'(o_req_valid), 32'd1);
    check("rst_req_addr", o_req_addr, use_b ? PC_B : PC_A);
  endtask

  task automatic wait_redirect(input string tag, input int bound);
    for (int i = 0; i < bound && !redir_done; i++) step();
    check(tag, 32'(redir_done), 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst_a = 1'b1; rst_b = 1'b1; sel_b = 1'b0;
    pc_src = 1'b0; branch_target = 32'h0; mem_ready = 1'b0;
    resp_valid = 1'b0; resp_data = 32'h0; instr_ready = 1'b0;
    base_ready = 1'b1; base_consume = 1'b1; mem_lat = 1;
    redir_target = 32'h0;

    // 1: streaming fetch, 1-cycle memory, consumer always ready.
    do_reset(1'b0);
    base_ready = 1'b1; base_consume = 1'b1; mem_lat = 1;
    for (int i = 0; i < 6; i++) exp_req_q.push_back(PC_A + 32'(4 * i));
    run(20);
    check("t1_first_accept", 32'(first_accept), 32'd0);
    check("t1_accept_to_valid", 32'(first_valid - first_accept), 32'd2);
    check("t1_progress", 32'(n_consume >= 8), 32'd1);

    // 2: consumer stalls, FIFO fills to two words, then drains in order.
    do_reset(1'b0);
    base_consume = 1'b0;
    run(10);
    check("t2_accepts", 32'(n_accept), 32'd2);
    check("t2_req_valid", 32'(o_req_valid), 32'd0);
    check("t2_instr_valid", 32'(o_ivalid), 32'd1);
    check("t2_head_pc_plus8", o_pcp8, PC_A + 32'd8);
    check("t2_head_instr", o_instr, mem_word(PC_A));
    base_consume = 1'b1;
    run(12);
    check("t2_drained", 32'(n_consume >= 3), 32'd1);

    // 5 + 3: wrap from 0xFFFFFFF8, then redirect with two requests outstanding.
    do_reset(1'b1);
    mem_lat = 3;
    exp_req_q.push_back(32'hFFFF_FFF8);
    exp_req_q.push_back(32'hFFFF_FFFC);
    exp_req_q.push_back(32'h0000_0000);
    exp_req_q.push_back(32'h0000_0004);
    run(10);
    check("t5_wrap_consumed", 32'(n_consume >= 3), 32'd1);
    redir_target = 32'h0000_0100;
    redir_mode = 1;
    wait_redirect("t3_redirect_seen", 40);
    base = n_consume;
    run(15);
    check("t3_new_path", 32'(n_consume - base >= 2), 32'd1);

    // 4: redirect coinciding with an accept and a response; unaligned target.
    do_reset(1'b1);
    mem_lat = 2;
    run(8);
    redir_target = 32'h0000_0202;
    redir_mode = 2;
    wait_redirect("t4_redirect_seen", 40);
    base = n_consume;
    run(15);
    check("t4_new_path", 32'(n_consume - base >= 2), 32'd1);

    // 6: reset in the middle of a stall with a full FIFO.
    do_reset(1'b0);
    mem_lat = 1;
    base_consume = 1'b0;
    run(8);
    check("t6_full_valid", 32'(o_ivalid), 32'd1);
    check("t6_full_no_req", 32'(o_req_valid), 32'd0);
    rst_a = 1'b1;
    step();
    check("t6_req_in_reset", 32'(o_req_valid), 32'd0);
    do_reset(1'b0);
    base_consume = 1'b1;
    run(10);
    check("t6_restart", 32'(n_consume >= 3), 32'd1);

    // 7: random backpressure, latency and redirects on both configurations.
    for (int d = 0; d < 2; d++) begin
      do_reset(d == 1);
      rand_ready = 1'b1; rand_consume = 1'b1; rand_lat = 1'b1;
      redir_mode = 3;
      run(300);
      check("t7_progress", 32'(n_consume > 20), 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
